mux_8_to_1: RTL and testbench
=============================

// Module: mux_8_to_1
// PURPOSE
//   8-input, 3-bit-select multiplexer used as a leaf primitive in the MIPS
//   datapath (e.g. ALU-result and write-back source selection).
//   Provides a combinational output z and a registered copy z_q for
//   pipelined consumers.
// PARAMETERS
//   WIDTH  1  bit width of each data input and of both outputs
// PORTS
//   clk  input   1      rising-edge clock; used only by z_q
//   rst  input   1      synchronous, active-high reset
//   s    input   3      select; s[2] MSB
//   i7   input   WIDTH  data input chosen when s=3'b111
//   i6   input   WIDTH  data input chosen when s=3'b110
//   i5   input   WIDTH  data input chosen when s=3'b101
//   i4   input   WIDTH  data input chosen when s=3'b100
//   i3   input   WIDTH  data input chosen when s=3'b011
//   i2   input   WIDTH  data input chosen when s=3'b010
//   i1   input   WIDTH  data input chosen when s=3'b001
//   i0   input   WIDTH  data input chosen when s=3'b000
//   z    output  WIDTH  combinational selected input
//   z_q  output  WIDTH  z registered on clk
//   en   input   1      z_q load enable; present only with MUX_8_TO_1_HOLD_EN
// BEHAVIOUR
//   - Clock: single clock clk; reset rst is synchronous and active-high.
//   - Select mapping: z = i[s], where i[k] is input ik. Selected index
//     k = 4*s[2] + 2*s[1] + s[0].
//   - z is purely combinational with zero latency; it is not affected by
//     rst or clk.
//   - z follows any change on s or on the selected input within the same
//     delta. Changes on unselected inputs never change z.
//   - Bitwise X/Z semantics:
//     - If s contains X/Z, z is X wherever the candidate inputs differ.
//     - No latch is inferred; every s value is decoded.
//   - z_q:
//     - Updates to z on each rising clk edge; latency is one cycle.
//     - While rst=1 at an edge, z_q <= 0 (all WIDTH bits).
//     - rst takes priority over en.
//     - Reset asserted mid-stream clears z_q at the next edge only.
//       z is unaffected.
//   - All WIDTH bits are selected by the same s. No bit mixing.
// CONFIGURATION
//   MUX_8_TO_1_HOLD_EN:
//     - Defined: adds input en. z_q loads z only when en=1 and rst=0;
//       with en=0 it holds its value.
//     - Undefined: no en port, and z_q loads z on every non-reset edge.
//   z behaviour is identical in both builds.
// STRUCTURE
//   - Package mux_8_to_1_pkg holds:
//     - localparam SEL_W=3 and N_IN=8.
//     - Named select constants SEL_I0..SEL_I7 (3'b000..3'b111).
//   - Sub-module mux_2_to_1 (WIDTH param; ports s, i1, i0, z).
//     - Seven instances form a 3-level tree.
//     - Level 1 is driven by s[0], level 2 by s[1], root by s[2].
//   - The z_q register is a single always block in the top module.
// TESTING
//   - All inputs 0, s=000: z=0. Then set i2=i4=i5=1, s=010: z=1 (i2).
//   - s=011 with i3=0: z=0. Then s=111 with i7=0: z=0.
//     Then set i7=1: z=1 immediately.
//   - s=101 with i5=1: z=1. Toggle i4/i6 while s=101: z stays 1.
//   - Exhaustive sweep: for each s in 0..7, one-hot i[s]=1 gives z=1 and
//     all-but-i[s] gives z=0.
//   - Reset: z=1, rst=1 at an edge gives z_q=0. Release rst: z_q=1 one
//     cycle later.
//   - HOLD_EN build: en=0 and change z: z_q holds. en=1: z_q=z after one edge.

Source files
------------

// File: rtl/mux_8_to_1_pkg.sv
// mux_8_to_1_pkg
//   Shared constants for the 8:1 multiplexer and its 2:1 leaf cell.
//   SEL_W / N_IN size the select and the input count. SEL_I0..SEL_I7
//   name each select code, so callers can write SEL_I5 rather than 3'b101.
//   sel_index() turns a select code into the index of the input it picks.
package mux_8_to_1_pkg;

  localparam int SEL_W = 3;
  localparam int N_IN  = 8;

  localparam logic [SEL_W-1:0] SEL_I0 = 3'b000;
  localparam logic [SEL_W-1:0] SEL_I1 = 3'b001;
  localparam logic [SEL_W-1:0] SEL_I2 = 3'b010;
  localparam logic [SEL_W-1:0] SEL_I3 = 3'b011;
  localparam logic [SEL_W-1:0] SEL_I4 = 3'b100;
  localparam logic [SEL_W-1:0] SEL_I5 = 3'b101;
  localparam logic [SEL_W-1:0] SEL_I6 = 3'b110;
  localparam logic [SEL_W-1:0] SEL_I7 = 3'b111;

  // Index of the input selected by code sel: 4*s[2] + 2*s[1] + s[0].
  function automatic int unsigned sel_index(input logic [SEL_W-1:0] sel);
    return (int'(sel[2]) * 4) + (int'(sel[1]) * 2) + int'(sel[0]);
  endfunction

endpackage

// File: rtl/mux_2_to_1.sv
// mux_2_to_1
//   Leaf 2:1 multiplexer, WIDTH bits wide. All bits share one select.
//   Ports:
//     s   in  1      select; 1 picks i1, 0 picks i0
//     i1  in  WIDTH  data input chosen when s=1
//     i0  in  WIDTH  data input chosen when s=0
//     z   out WIDTH  selected input (combinational)
//   The conditional operator is used on purpose. If s is X/Z, each bit of
//   z is X only where i1 and i0 differ, so X-propagation is accurate.
import mux_8_to_1_pkg::*;

module mux_2_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             s,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] z
);

  assign z = s ? i1 : i0;

endmodule

// File: rtl/mux_8_to_1.sv
// mux_8_to_1
//   8-input multiplexer with a 3-bit select, WIDTH bits wide. It drives
//   two outputs:
//     z    the selected input, combinational, with no dependence on clk
//          or rst
//     z_q  a copy of z, registered on clk
//   The select logic is a 3-level tree of mux_2_to_1 cells. s[0] drives
//   the leaf level, s[1] the middle level and s[2] the root.
//   Ports:
//     clk  in  1      rising-edge clock (used only by z_q)
//     rst  in  1      synchronous, active-high reset of z_q
//     s    in  3      select; s[2] is the MSB
//     i7..i0 in WIDTH data inputs; ik is chosen when s == k
//     z    out WIDTH  combinational selected input
//     z_q  out WIDTH  z registered on clk
//     en   in  1      z_q load enable (exists only with MUX_8_TO_1_HOLD_EN)
//   Build option MUX_8_TO_1_HOLD_EN:
//     defined   - adds en; z_q loads z only when en=1, otherwise holds
//     undefined - z_q loads z on every edge where rst is low
import mux_8_to_1_pkg::*;

module mux_8_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] s,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
`ifdef MUX_8_TO_1_HOLD_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q
);

  // Leaf level, pairs (i1,i0) (i3,i2) (i5,i4) (i7,i6), selected by s[0]
  logic [WIDTH-1:0] l1_10;
  logic [WIDTH-1:0] l1_32;
  logic [WIDTH-1:0] l1_54;
  logic [WIDTH-1:0] l1_76;

  // Middle level, selected by s[1]
  logic [WIDTH-1:0] l2_lo;
  logic [WIDTH-1:0] l2_hi;

  mux_2_to_1 #(.WIDTH(WIDTH)) u_l1_10 (.s(s[0]), .i1(i1), .i0(i0), .z(l1_10));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_l1_32 (.s(s[0]), .i1(i3), .i0(i2), .z(l1_32));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_l1_54 (.s(s[0]), .i1(i5), .i0(i4), .z(l1_54));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_l1_76 (.s(s[0]), .i1(i7), .i0(i6), .z(l1_76));

  mux_2_to_1 #(.WIDTH(WIDTH)) u_l2_lo (.s(s[1]), .i1(l1_32), .i0(l1_10), .z(l2_lo));
  mux_2_to_1 #(.WIDTH(WIDTH)) u_l2_hi (.s(s[1]), .i1(l1_76), .i0(l1_54), .z(l2_hi));

  mux_2_to_1 #(.WIDTH(WIDTH)) u_root (.s(s[2]), .i1(l2_hi), .i0(l2_lo), .z(z));

  // Pipelined copy of z. rst has priority over the optional enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
`ifdef MUX_8_TO_1_HOLD_EN
    end else if (en) begin
      z_q <= z;
`else
    end else begin
      z_q <= z;
`endif
    end
  end

endmodule

// File: tb/tb_mux_8_to_1.sv
module tb_mux_8_to_1;
  import mux_8_to_1_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] s;
  logic [7:0] vec;
  logic       z;
  logic       z_q;
`ifdef MUX_8_TO_1_HOLD_EN
  logic       en;
`endif

  int errors = 0;
  int checks = 0;

  mux_8_to_1 #(.WIDTH(1)) dut (
    .clk(clk),
    .rst(rst),
    .s  (s),
    .i7 (vec[7]),
    .i6 (vec[6]),
    .i5 (vec[5]),
    .i4 (vec[4]),
    .i3 (vec[3]),
    .i2 (vec[2]),
    .i1 (vec[1]),
    .i0 (vec[0]),
`ifdef MUX_8_TO_1_HOLD_EN
    .en (en),
`endif
    .z  (z),
    .z_q(z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    s   = SEL_I0;
    vec = 8'h00;
`ifdef MUX_8_TO_1_HOLD_EN
    en  = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_z", z, 1'b0);
    check("reset_zq", z_q, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    vec = 8'b0011_0100;  // i2=i4=i5=1
    s   = SEL_I2;
    #1 check("sel_i2", z, 1'b1);
    s = SEL_I3;
    #1 check("sel_i3_zero", z, 1'b0);
    s = SEL_I7;
    #1 check("sel_i7_zero", z, 1'b0);
    vec[7] = 1'b1;
    #1 check("sel_i7_follow", z, 1'b1);

    vec[7] = 1'b0;
    s = SEL_I5;
    #1 check("sel_i5", z, 1'b1);
    vec[4] = 1'b0; vec[6] = 1'b1;
    #1 check("i5_unsel_toggle_a", z, 1'b1);
    vec[4] = 1'b1; vec[6] = 1'b0;
    #1 check("i5_unsel_toggle_b", z, 1'b1);

    for (int k = 0; k < 8; k++) begin
      s   = 3'(k);
      vec = 8'(1 << k);
      #1 check($sformatf("onehot_s%0d", k), z, 1'b1);
      vec = ~(8'(1 << k));
      #1 check($sformatf("allbut_s%0d", k), z, 1'b0);
    end

    // registered path: z=1, reset, release, latency
    @(negedge clk);
    s   = SEL_I3;
    vec = 8'b0000_1000;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_clears_zq", z_q, 1'b0);
    check("rst_keeps_z", z, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1 check("zq_before_edge", z_q, 1'b0);
    @(posedge clk); #1;
    check("zq_after_release", z_q, 1'b1);
    @(negedge clk);
    vec = 8'h00;
    #1 check("zq_holds_until_edge", z_q, 1'b1);
    @(posedge clk); #1;
    check("zq_follows_zero", z_q, 1'b0);

`ifdef MUX_8_TO_1_HOLD_EN
    @(negedge clk);
    en  = 1'b0;
    vec = 8'b0000_1000;
    @(posedge clk); #1;
    check("en0_holds", z_q, 1'b0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("en1_loads", z_q, 1'b1);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_over_en", z_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
